// File: rtl/y_wb_pkg.sv
// Shared types and sizing for the Y-matrix row write-back engine.
package y_wb_pkg;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 256;
    localparam int SLOT_W     = 16;
    localparam int SLOTS      = DATA_W / SLOT_W;
    localparam int SLOT_SEL_W = 4;
    localparam int LSB_W      = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPT,
        WRITE
    } wb_state_e;

endpackage

// File: rtl/y_slot_merge.sv
// Combinational slot merge: replaces one 16-bit slot of a row, or adds to it
// with the carry dropped. Used for both SRAM-sourced and cache-sourced rows.
module y_slot_merge
    import y_wb_pkg::*;
(
    input  logic [DATA_W-1:0]     row_i,
    input  logic [SLOT_SEL_W-1:0] slot_i,
    input  logic                  mode_i,
    input  logic [SLOT_W-1:0]     value_i,
    output logic [DATA_W-1:0]     row_o
);

    logic [LSB_W-1:0]  lsb;
    logic [SLOT_W-1:0] oldSlot;

    always_comb begin
        row_o   = row_i;
        lsb     = LSB_W'(slot_i) * LSB_W'(SLOT_W);
        oldSlot = row_i[lsb +: SLOT_W];
        row_o[lsb +: SLOT_W] = mode_i ? (oldSlot + value_i) : value_i;
    end

endmodule

// File: rtl/y_row_writer.sv
// Read-modify-write engine for one 256-bit Y-matrix row per change request.
// Define Y_ROW_WB_BYPASS_EN to keep the last written row cached and skip its SRAM read.
module y_row_writer
    import y_wb_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_row,
    input  logic [ADDR_W-1:0]    req_col,
    input  logic                 req_mode,
    input  logic [SLOT_W-1:0]    req_value,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic                 sram_rd_en,
    input  logic [DATA_W-1:0]    sram_rd_data,
    output logic                 sram_wr_en,
    output logic [DATA_W-1:0]    sram_wr_data,
    output logic                 done,
    output logic                 err,
    input  logic                 cache_inv
);

    wb_state_e             state_q;
    logic                  ready_q;
    logic                  rdEn_q;
    logic                  wrEn_q;
    logic                  done_q;
    logic                  err_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [SLOT_SEL_W-1:0] slot_q;
    logic                  mode_q;
    logic [SLOT_W-1:0]     value_q;
    logic [DATA_W-1:0]     wrData_q;
    logic [DATA_W-1:0]     mergeSrc;
    logic [DATA_W-1:0]     mergedRow_d;
    logic                  transfer;
    logic                  colBad;
    logic                  takeCache;

    assign transfer = req_valid && ready_q;
    assign colBad   = |req_col[ADDR_W-1:SLOT_SEL_W];

`ifdef Y_ROW_WB_BYPASS_EN
    logic [ADDR_W-1:0] cacheRow_q;
    logic              cacheValid_q;
    logic              hit_q;

    // wrData_q keeps the last merged row until the next CAPT, so it doubles as the cached data.
    assign takeCache = cacheValid_q && !cache_inv && (req_row == cacheRow_q);
    assign mergeSrc  = hit_q ? wrData_q : sram_rd_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            cacheValid_q <= 1'b0;
            cacheRow_q   <= '0;
            hit_q        <= 1'b0;
        end else begin
            if (state_q == IDLE && transfer && !colBad) begin
                hit_q <= takeCache;
            end
            if (cache_inv) begin
                cacheValid_q <= 1'b0;
            end else if (state_q == WRITE) begin
                cacheValid_q <= 1'b1;
                cacheRow_q   <= addr_q;
            end
        end
    end
`else
    logic unused_cache_inv;

    assign takeCache        = 1'b0;
    assign mergeSrc         = sram_rd_data;
    assign unused_cache_inv = cache_inv;
`endif

    y_slot_merge uMerge (
        .row_i   (mergeSrc),
        .slot_i  (slot_q),
        .mode_i  (mode_q),
        .value_i (value_q),
        .row_o   (mergedRow_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            rdEn_q   <= 1'b0;
            wrEn_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            slot_q   <= '0;
            mode_q   <= 1'b0;
            value_q  <= '0;
            wrData_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (transfer) begin
                        if (colBad) begin
                            err_q <= 1'b1;
                        end else begin
                            ready_q <= 1'b0;
                            addr_q  <= req_row;
                            slot_q  <= req_col[SLOT_SEL_W-1:0];
                            mode_q  <= req_mode;
                            value_q <= req_value;
                            if (takeCache) begin
                                state_q <= CAPT;
                            end else begin
                                state_q <= READ;
                                rdEn_q  <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    rdEn_q  <= 1'b0;
                    state_q <= CAPT;
                end
                CAPT: begin
                    wrData_q <= mergedRow_d;
                    wrEn_q   <= 1'b1;
                    done_q   <= 1'b1;
                    state_q  <= WRITE;
                end
                WRITE: begin
                    wrEn_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are squashed while reset is high so a reset landing in WRITE never reaches the SRAM.
    assign req_ready    = ready_q && !reset;
    assign sram_rd_en   = rdEn_q && !reset;
    assign sram_wr_en   = wrEn_q && !reset;
    assign done         = done_q && !reset;
    assign err          = err_q && !reset;
    assign sram_addr    = addr_q;
    assign sram_wr_data = wrData_q;

endmodule

// File: tb/tb_y_row_writer.sv
// Self-checking bench for y_row_writer: transaction-level model plus directed cases.
// Bypass-specific expectations follow Y_ROW_WB_BYPASS_EN.
module tb_y_row_writer;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         reqValid = 1'b0;
    logic         reqReady;
    logic [10:0]  reqRow = '0;
    logic [10:0]  reqCol = '0;
    logic         reqMode = 1'b0;
    logic [15:0]  reqValue = '0;
    logic [10:0]  sramAddr;
    logic         sramRdEn;
    logic [255:0] sramRdData = '0;
    logic         sramWrEn;
    logic [255:0] sramWrData;
    logic         done;
    logic         err;
    logic         cacheInv = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    y_row_writer dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (reqValid),
        .req_ready    (reqReady),
        .req_row      (reqRow),
        .req_col      (reqCol),
        .req_mode     (reqMode),
        .req_value    (reqValue),
        .sram_addr    (sramAddr),
        .sram_rd_en   (sramRdEn),
        .sram_rd_data (sramRdData),
        .sram_wr_en   (sramWrEn),
        .sram_wr_data (sramWrData),
        .done         (done),
        .err          (err),
        .cache_inv    (cacheInv)
    );

    always #5 clock = ~clock;

    // Power-on contents of the rows the directed cases touch
    function automatic logic [255:0] initRow(input int r);
        case (r)
            5:       return {16{16'h0001}};
            7:       return {16'hFFF0, {15{16'h1234}}};
            9:       return {16{16'h0909}};
            2047:    return {{15{16'hAAAA}}, 16'h0100};
            default: return '0;
        endcase
    endfunction

    function automatic logic [255:0] mergeRow(input logic [255:0] row, input int slot,
                                              input bit add, input logic [15:0] value);
        logic [255:0] mask;
        logic [15:0]  cur;
        logic [15:0]  nxt;
        mask = 256'hFFFF << (16 * slot);
        cur  = 16'(row >> (16 * slot));
        nxt  = add ? 16'(cur + value) : value;
        return (row & ~mask) | (256'(nxt) << (16 * slot));
    endfunction

    // SRAM behaviour: one-cycle read latency, writes land at the strobe
    logic [255:0] sramMem [int];

    function automatic logic [255:0] sramRead(input int a);
        return sramMem.exists(a) ? sramMem[a] : initRow(a);
    endfunction

    always @(posedge clock) begin
        if (sramRdEn) sramRdData <= sramRead(int'(sramAddr));
        if (sramWrEn) sramMem[int'(sramAddr)] = sramWrData;
    end

    // Reference model: schedules each accepted request's strobes by latency
    int           cyc = 0;
    int           readyFrom = 1 << 30;
    int           rdCyc = -1;
    int           wrCyc = -1;
    int           errCyc = -1;
    bit           checkEn = 1'b0;
    logic [10:0]  expAddr = '0;
    logic [10:0]  lastAddr = '0;
    logic [255:0] expData = '0;
    logic [255:0] modelMem [int];
    bit           cacheValid = 1'b0;
    logic [10:0]  cacheRow = '0;
    logic [255:0] cacheData = '0;

    function automatic logic [255:0] modelRead(input int a);
        return modelMem.exists(a) ? modelMem[a] : initRow(a);
    endfunction

    always @(posedge clock) begin : model
        bit           hit;
        logic [255:0] base;
        if (reset) begin
            readyFrom  = cyc + 2;
            rdCyc      = -1;
            wrCyc      = -1;
            errCyc     = -1;
            lastAddr   = '0;
            cacheValid = 1'b0;
            checkEn    = 1'b1;
        end else begin
            if (cyc == wrCyc) begin
                modelMem[int'(expAddr)] = expData;
                cacheValid = 1'b1;
                cacheRow   = expAddr;
                cacheData  = expData;
            end
            if (cacheInv) cacheValid = 1'b0;
            if (reqValid && cyc >= readyFrom) begin
                if (reqCol[10:4] != 7'd0) begin
                    errCyc = cyc + 1;
                end else begin
`ifdef Y_ROW_WB_BYPASS_EN
                    hit = cacheValid && (cacheRow == reqRow);
`else
                    hit = 1'b0;
`endif
                    base     = hit ? cacheData : modelRead(int'(reqRow));
                    expData  = mergeRow(base, int'(reqCol[3:0]), reqMode, reqValue);
                    expAddr  = reqRow;
                    lastAddr = reqRow;
                    rdCyc    = hit ? -1 : cyc + 1;
                    wrCyc    = hit ? cyc + 2 : cyc + 3;
                    readyFrom = wrCyc + 1;
                end
            end
        end
        cyc = cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin : compare
        bit eRd;
        bit eWr;
        bit eErr;
        bit eRdy;
        if (checkEn) begin
            eRd  = !reset && (cyc == rdCyc);
            eWr  = !reset && (cyc == wrCyc);
            eErr = !reset && (cyc == errCyc);
            eRdy = !reset && (cyc >= readyFrom);
            checkOutput("req_ready", reqReady, eRdy);
            checkOutput("sram_rd_en", sramRdEn, eRd);
            checkOutput("sram_wr_en", sramWrEn, eWr);
            checkOutput("done", done, eWr);
            checkOutput("err", err, eErr);
            if (eRd || eWr) checkOutput("sram_addr", sramAddr, expAddr);
            else if (eRdy) checkOutput("sram_addr_idle", sramAddr, lastAddr);
            if (eWr) checkOutput("sram_wr_data", sramWrData, expData);
        end
    end

    // Event capture for the directed literal checks
    int           rdCount = 0;
    int           wrCount = 0;
    int           errCount = 0;
    int           lastRdCyc = -100;
    int           lastWrCyc = -100;
    int           lastErrCyc = -100;
    logic [255:0] lastWrData = '0;

    always @(negedge clock) begin
        if (sramRdEn) begin
            rdCount++;
            lastRdCyc = cyc;
        end
        if (sramWrEn) begin
            wrCount++;
            lastWrCyc  = cyc;
            lastWrData = sramWrData;
        end
        if (err) begin
            errCount++;
            lastErrCyc = cyc;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [10:0] row, input logic [10:0] col, input bit add,
                                 input logic [15:0] value, input bit inv, output int acceptCyc);
        int waited;
        waited    = 0;
        acceptCyc = -1;
        @(negedge clock);
        while (!reqReady && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!reqReady) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL ready_timeout: req_ready still %0b after %0d cycles, expected 1", reqReady, waited);
        end else begin
            reqRow    = row;
            reqCol    = col;
            reqMode   = add;
            reqValue  = value;
            cacheInv  = inv;
            reqValid  = 1'b1;
            acceptCyc = cyc;
            @(posedge clock);
            #1;
            reqValid = 1'b0;
            cacheInv = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a;
        int b;
        int rd0;
        int wr0;
        int err0;
        logic [255:0] exp1;
        logic [255:0] exp2;
        logic [255:0] exp4;
        logic [255:0] exp7;
        logic [255:0] exp8;
        logic [255:0] exp10;

        exp1  = {{12{16'h0001}}, 16'hBEEF, {3{16'h0001}}};
        exp2  = {16'h0010, {15{16'h1234}}};
        exp4  = {{15{16'hAAAA}}, 16'h0123};
        exp7  = {{14{16'h0909}}, 16'h2222, 16'h1111};
        exp8  = {{13{16'h0909}}, 16'h3333, 16'h2222, 16'h1111};
        exp10 = {{11{16'h0909}}, 16'h090A, 16'h4444, 16'h3333, 16'h2222, 16'h1111};

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_ready_low", reqReady, 1'b0);
        checkOutput("rst_wr_en", sramWrEn, 1'b0);
        checkOutput("rst_addr", sramAddr, 11'd0);
        @(negedge clock);
        checkOutput("rst_ready_high", reqReady, 1'b1);

        $display("[TB] replace row 5 slot 3");
        rd0 = rdCount;
        applyStimulus(11'd5, 11'd3, 1'b0, 16'hBEEF, 1'b0, a);
        waitCycles(5);
        checkOutput("t1_rd_latency", lastRdCyc - a, 1);
        checkOutput("t1_wr_latency", lastWrCyc - a, 3);
        checkOutput("t1_reads", rdCount - rd0, 1);
        checkOutput("t1_slot3", lastWrData[63:48], 16'hBEEF);
        checkOutput("t1_row", lastWrData, exp1);
        checkOutput("t1_model_row", modelRead(5), exp1);

        $display("[TB] add with wrap on row 7 slot 15");
        applyStimulus(11'd7, 11'h00F, 1'b1, 16'h0020, 1'b0, a);
        waitCycles(5);
        checkOutput("t2_wr_latency", lastWrCyc - a, 3);
        checkOutput("t2_slot15", lastWrData[255:240], 16'h0010);
        checkOutput("t2_row", lastWrData, exp2);

        $display("[TB] out-of-range column");
        rd0  = rdCount;
        wr0  = wrCount;
        err0 = errCount;
        applyStimulus(11'd5, 11'h010, 1'b0, 16'hDEAD, 1'b0, a);
        waitCycles(5);
        checkOutput("t3_err_latency", lastErrCyc - a, 1);
        checkOutput("t3_err_count", errCount - err0, 1);
        checkOutput("t3_no_read", rdCount - rd0, 0);
        checkOutput("t3_no_write", wrCount - wr0, 0);
        checkOutput("t3_ready", reqReady, 1'b1);

        $display("[TB] add on last row slot 0");
        applyStimulus(11'h7FF, 11'h000, 1'b1, 16'h0023, 1'b0, a);
        waitCycles(5);
        checkOutput("t4_row", lastWrData, exp4);

        $display("[TB] reset in CAPT");
        rd0 = rdCount;
        wr0 = wrCount;
        applyStimulus(11'd5, 11'd4, 1'b0, 16'h5555, 1'b0, a);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("t5_ready_low", reqReady, 1'b0);
        checkOutput("t5_wr_en_low", sramWrEn, 1'b0);
        checkOutput("t5_done_low", done, 1'b0);
        @(negedge clock);
        checkOutput("t5_ready_back", reqReady, 1'b1);
        waitCycles(4);
        checkOutput("t5_no_write", wrCount - wr0, 0);
        checkOutput("t5_one_read", rdCount - rd0, 1);

        $display("[TB] reset in WRITE");
        wr0 = wrCount;
        applyStimulus(11'd5, 11'd4, 1'b0, 16'h6666, 1'b0, a);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        waitCycles(5);
        checkOutput("t6_no_write", wrCount - wr0, 0);
        checkOutput("t6_row5_kept", sramRead(5), exp1);

        $display("[TB] back-to-back on row 9");
        rd0 = rdCount;
        applyStimulus(11'd9, 11'd0, 1'b0, 16'h1111, 1'b0, a);
        applyStimulus(11'd9, 11'd1, 1'b0, 16'h2222, 1'b0, b);
        waitCycles(5);
        checkOutput("t7_gap", b - a, 4);
`ifdef Y_ROW_WB_BYPASS_EN
        checkOutput("t7_wr_latency", lastWrCyc - b, 2);
        checkOutput("t7_reads", rdCount - rd0, 1);
`else
        checkOutput("t7_wr_latency", lastWrCyc - b, 3);
        checkOutput("t7_reads", rdCount - rd0, 2);
`endif
        checkOutput("t7_row", lastWrData, exp7);

        $display("[TB] invalidate between requests");
        @(posedge clock);
        #1 cacheInv = 1'b1;
        @(posedge clock);
        #1 cacheInv = 1'b0;
        rd0 = rdCount;
        applyStimulus(11'd9, 11'd2, 1'b0, 16'h3333, 1'b0, a);
        waitCycles(5);
        checkOutput("t8_wr_latency", lastWrCyc - a, 3);
        checkOutput("t8_reads", rdCount - rd0, 1);
        checkOutput("t8_row", lastWrData, exp8);

        $display("[TB] invalidate with transfer, then hit");
        rd0 = rdCount;
        applyStimulus(11'd9, 11'd3, 1'b0, 16'h4444, 1'b1, a);
        waitCycles(5);
        checkOutput("t9_wr_latency", lastWrCyc - a, 3);
        checkOutput("t9_reads", rdCount - rd0, 1);
        rd0 = rdCount;
        applyStimulus(11'd9, 11'd4, 1'b1, 16'h0001, 1'b0, a);
        waitCycles(5);
`ifdef Y_ROW_WB_BYPASS_EN
        checkOutput("t10_wr_latency", lastWrCyc - a, 2);
        checkOutput("t10_reads", rdCount - rd0, 0);
`else
        checkOutput("t10_wr_latency", lastWrCyc - a, 3);
        checkOutput("t10_reads", rdCount - rd0, 1);
`endif
        checkOutput("t10_row", lastWrData, exp10);

        waitCycles(3);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
